pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning consecutive memory-stall cycles before timeout_err sets.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width.
REQ-003 SHALL use one clock and a synchronous, active-high reset; ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  ID-stage source registers
- id_rs1_used, id_rs2_used  in  1  source operand valid
- ex_rd  in  REG_ADDR_W  EX-stage destination register
- ex_is_load  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump
- imem_ready  in  1  fetch data valid this cycle
- dmem_req, dmem_ready  in  1  MEM-stage access and its completion
- pc_write, if_id_write, id_ex_write, ex_mem_write  out  1  stage write enables
- if_id_flush, id_ex_bubble, mem_wb_bubble  out  1  clear/NOP-insert controls
- stall_state  out  2  registered cause: 0 RUN, 1 LU, 2 ISTALL, 3 DSTALL
- timeout_err  out  1  sticky watchdog flag

Function
REQ-004 SHALL drive all control outputs combinationally in the same cycle as their cause (zero latency); stall_state and timeout_err SHALL be registered.
REQ-005 SHALL resolve causes in fixed priority: DSTALL > branch flush > load-use > ISTALL > RUN.
REQ-006 DSTALL (dmem_req=1, dmem_ready=0) SHALL drive all four write enables 0 and mem_wb_bubble=1, with all other clears 0.
REQ-007 A branch flush (ex_branch_taken=1, no DSTALL) SHALL drive all write enables 1, if_id_flush=1 and id_ex_bubble=1, regardless of imem_ready.
REQ-008 Load-use (ex_is_load=1, ex_rd!=0, and a used rs equal to ex_rd) SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1, and the other write enables 1.
REQ-009 Load-use SHALL take precedence over ISTALL for IF/ID: IF/ID is held and not flushed.
REQ-010 ISTALL (imem_ready=0, no higher cause) SHALL drive pc_write=0 and if_id_flush=1, with the other enables 1.
REQ-011 RUN SHALL drive all write enables 1 and all clears 0.
REQ-012 stall_state SHALL register the winning cause each cycle; a branch flush SHALL register as RUN.
REQ-013 A wait counter SHALL increment in each consecutive ISTALL or DSTALL cycle, saturate at TIMEOUT_CYC, and clear in any other cycle.
REQ-014 Reaching TIMEOUT_CYC SHALL set timeout_err, which stays set until reset.
REQ-015 A switch between ISTALL and DSTALL SHALL NOT clear the wait counter.
REQ-016 Register 0 SHALL never cause a load-use stall.

Reset
REQ-017 While reset=1, outputs SHALL be forced to: all write enables 0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
REQ-018 Reset SHALL set stall_state=RUN, wait counter=0 and timeout_err=0 at the next edge, including mid-stall.

Configuration
REQ-019 With macro PIPE_HAZARD_PERF_EN defined, the block SHALL add outputs stall_cycles (32 bits) and flush_count (16 bits). Both SHALL be wrapping counters of non-RUN cycles and branch flushes, cleared by reset.
REQ-020 Without PIPE_HAZARD_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-021 Package pipe_ctrl_pkg SHALL hold the stall_state encoding typedef and REG_ADDR_W default.
REQ-022 The wait counter and watchdog SHALL be a sub-module stall_watchdog (parameter TIMEOUT_CYC; ports clk, reset, stall, timeout).

Verification
REQ-023 Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 in that cycle; stall_state=1 next cycle.
REQ-024 Register zero: same stimulus with ex_rd=0, id_rs1=0 -> RUN outputs, no stall.
REQ-025 Priority: dmem_req=1, dmem_ready=0, ex_branch_taken=1 -> all writes 0, if_id_flush=0; after dmem_ready=1 -> branch flush outputs.
REQ-026 Watchdog: TIMEOUT_CYC=4, imem_ready=0 for 2 cycles, then dmem stall for 2 cycles -> timeout_err=1 after the 4th stall cycle; it stays 1 after stalls end.
REQ-027 Reset mid-DSTALL: reset=1 for 1 cycle during a 10-cycle stall -> forced reset outputs, then stall_state=0, timeout_err=0, wait counter restarts.
REQ-028 PIPE_HAZARD_PERF_EN: 3 branch flushes plus 7 stall cycles -> flush_count=3, stall_cycles=7.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types for the pipeline hazard controller: the registered stall-cause
// encoding, the bundle of stage control signals, the default register-index
// width and a helper that maps a resolved cause onto that control bundle.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    // Encoding of the registered stall cause (branch flushes record as RUN)
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LU     = 2'd1,
        ST_ISTALL = 2'd2,
        ST_DSTALL = 2'd3
    } stall_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } ctrl_t;

    // Everything frozen and every stage register cleared/bubbled
    localparam ctrl_t RESET_CTRL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    // Map the winning cause onto stage controls; branch_flush only matters
    // when the cause itself is RUN.
    function automatic ctrl_t ctrl_for(input stall_state_e cause, input logic branch_flush);
        ctrl_t c;
        case (cause)
            ST_DSTALL: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            ST_LU:     c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            ST_ISTALL: c = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
            ST_RUN: begin
                if (branch_flush) begin
                    c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
                end else begin
                    c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
                end
            end
            default:   c = RESET_CTRL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// -----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive memory-stall cycles (saturating at TIMEOUT_CYC) and raises
// a sticky timeout flag once the count reaches TIMEOUT_CYC.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  synchronous, active-high; clears counter and flag
//   stall   in  current cycle is a fetch or data-memory stall
//   timeout out registered sticky watchdog flag
// Parameter TIMEOUT_CYC must be at least 1.
// -----------------------------------------------------------------------------
module stall_watchdog #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    output logic timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    // Next counter value and sticky flag; the flag sets in the same edge the
    // counter lands on its maximum.
    always_comb begin
        if (!stall) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_MAX) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q | (wait_cnt_d == CNT_MAX);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Five-stage pipeline hazard controller. Resolves data-memory stalls, taken
// branches, load-use hazards and fetch stalls (in that priority order) into
// zero-latency stage write enables and clear/bubble controls, records the
// winning cause in stall_state and runs a stall watchdog.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used           ID-stage source registers and validity
//   ex_rd, ex_is_load               EX-stage destination and load flag
//   ex_branch_taken                 EX resolved a taken branch/jump
//   imem_ready                      fetch data valid
//   dmem_req, dmem_ready            MEM-stage access and completion
//   pc_write .. ex_mem_write        stage write enables (combinational)
//   if_id_flush, id_ex_bubble,
//   mem_wb_bubble                   clear / NOP-insert controls (combinational)
//   stall_state                     registered cause 0 RUN,1 LU,2 ISTALL,3 DSTALL
//   timeout_err                     registered sticky watchdog flag
// Optional feature macro PIPE_HAZARD_PERF_EN adds stall_cycles (32b) and
// flush_count (16b) wrapping performance counters.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_branch_taken,
    input  logic                  imem_ready,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic                  mem_wb_bubble,
    output logic [1:0]            stall_state,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0]           stall_cycles,
    output logic [15:0]           flush_count,
`endif
    output logic                  timeout_err
);

    logic         dstall_s;
    logic         istall_s;
    logic         load_use_s;
    logic         branch_flush_s;
    logic         wd_stall_s;
    stall_state_e cause_s;
    ctrl_t        ctrl_s;
    stall_state_e stall_state_q;
    stall_state_e stall_state_d;

    // Raw hazard detection; register 0 is hardwired so it never creates a dependency
    always_comb begin
        dstall_s   = dmem_req & ~dmem_ready;
        istall_s   = ~imem_ready;
        load_use_s = ex_is_load && (ex_rd != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));
    end

    // Fixed-priority cause resolution; a taken branch records as RUN
    always_comb begin
        branch_flush_s = 1'b0;
        cause_s        = ST_RUN;
        if (dstall_s) begin
            cause_s = ST_DSTALL;
        end else if (ex_branch_taken) begin
            branch_flush_s = 1'b1;
        end else if (load_use_s) begin
            cause_s = ST_LU;
        end else if (istall_s) begin
            cause_s = ST_ISTALL;
        end else begin
            cause_s = ST_RUN;
        end
    end

    // Stage controls, overridden to the frozen/cleared pattern during reset
    always_comb begin
        if (reset) begin
            ctrl_s = RESET_CTRL;
        end else begin
            ctrl_s = ctrl_for(cause_s, branch_flush_s);
        end
        stall_state_d = cause_s;
        wd_stall_s    = (cause_s == ST_ISTALL) || (cause_s == ST_DSTALL);
    end

    // Registered record of the winning cause
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_state_q <= ST_RUN;
        end else begin
            stall_state_q <= stall_state_d;
        end
    end

    stall_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .stall   (wd_stall_s),
        .timeout (timeout_err)
    );

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [15:0] flush_count_q;
    logic [15:0] flush_count_d;

    // Wrapping event counters: non-RUN cycles and branch flushes
    always_comb begin
        stall_cycles_d = stall_cycles_q + ((cause_s != ST_RUN) ? 32'd1 : 32'd0);
        flush_count_d  = flush_count_q + (branch_flush_s ? 16'd1 : 16'd0);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 16'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

    assign pc_write      = ctrl_s.pc_write;
    assign if_id_write   = ctrl_s.if_id_write;
    assign id_ex_write   = ctrl_s.id_ex_write;
    assign ex_mem_write  = ctrl_s.ex_mem_write;
    assign if_id_flush   = ctrl_s.if_id_flush;
    assign id_ex_bubble  = ctrl_s.id_ex_bubble;
    assign mem_wb_bubble = ctrl_s.mem_wb_bubble;
    assign stall_state   = stall_state_q;

endmodule
